// File: rtl/periph_rx_fsm.sv
// Peripheral-side receiver for the CPU four-phase send/ack handshake.
// Accepted words land in a small FIFO that a local consumer drains through a registered read port.
module periph_rx_fsm #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level,
  output logic [CNT_W-1:0]  rx_count,
  output logic              state_dbg
);

  // Handshake: the CPU raises send with data valid.
  // A word is taken only in IDLE with room, and ack then stays high until send drops.
  // A pop is taken when rd_en=1 and empty=0, and rd_valid pulses on the following cycle.
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              wr_en;
  logic              rd_fire;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (send && !full) begin
          wr_en     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!send) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ack       = (state == ACK);
  assign state_dbg = state;

  // The extra top pointer bit tells full apart from empty when the index bits match.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rx_count <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 1'b1;
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_periph_rx_fsm.sv
// Bench for periph_rx_fsm: directed handshake and read-port sequences.
// Popped words are scoreboarded against the order in which they were accepted.
module tb_periph_rx_fsm;

  logic       clk;
  logic       rst;
  logic       send;
  logic [3:0] data;
  logic       ack;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic [7:0] rx_count;
  logic       state_dbg;

  logic [3:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  periph_rx_fsm #(.DATA_W(4), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .send(send), .data(data), .ack(ack),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .level(level), .rx_count(rx_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    exp_q.delete();
    #3;
    rst = 1'b1;
    tick();
  endtask

  // driver: one full four-phase transfer, bounded wait for ack
  task automatic xfer(input logic [3:0] d);
    int n;
    send = 1'b1;
    data = d;
    tick();
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    check("xfer_ack_rise", ack, 1);
    if (ack) exp_q.push_back(d);
    send = 1'b0;
    tick();
    check("xfer_ack_fall", ack, 0);
  endtask

  // scoreboard monitor
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got %0h expected no pop", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; send = 1'b0; data = 4'h0; rd_en = 1'b0;
    #12;
    check("rst_ack", ack, 0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b1;
    tick();

    // single transfer of 4'hA with exact latencies
    send = 1'b1; data = 4'hA;
    tick();
    check("a_ack_rise", ack, 1);
    check("a_level", level, 1);
    check("a_rx_count", rx_count, 1);
    exp_q.push_back(4'hA);
    send = 1'b0;
    tick();
    check("a_ack_fall", ack, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("a_rd_valid", rd_valid, 1);
    tick();
    check("a_rd_valid_pulse", rd_valid, 0);
    check("a_empty", empty, 1);

    // send held 10 cycles with toggling data
    do_reset();
    send = 1'b1; data = 4'h3;
    tick();
    exp_q.push_back(4'h3);
    for (int i = 0; i < 9; i++) begin
      data = ~data;
      tick();
      check("hold_ack", ack, 1);
    end
    send = 1'b0;
    tick();
    check("hold_rx_count", rx_count, 1);
    check("hold_level", level, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();

    // backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) xfer(4'(i));
    check("bp_full", full, 1);
    check("bp_level4", level, 4);
    send = 1'b1; data = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ack_held", ack, 0);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("bp_ack_pop_edge", ack, 0);
    check("bp_full_after_pop", full, 0);
    tick();
    check("bp_ack_accept", ack, 1);
    check("bp_level_after", level, 4);
    exp_q.push_back(4'h5);
    send = 1'b0;
    tick();
    rd_en = 1'b1;
    repeat (4) tick();
    rd_en = 1'b0;
    tick();
    check("bp_drain_empty", empty, 1);

    // simultaneous write and pop at level 2
    do_reset();
    xfer(4'h6);
    xfer(4'h7);
    check("sim_level_pre", level, 2);
    send = 1'b1; data = 4'h8; rd_en = 1'b1;
    tick();
    check("sim_ack", ack, 1);
    check("sim_level_same", level, 2);
    exp_q.push_back(4'h8);
    send = 1'b0; rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    tick();
    check("sim_empty", empty, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_valid", rd_valid, 0);
    check("empty_rd_hold", rd_data, 4'h8);

    // reset asserted while in ACK with level 3
    do_reset();
    xfer(4'h1);
    xfer(4'h2);
    send = 1'b1; data = 4'h3;
    tick();
    check("mid_ack", ack, 1);
    check("mid_level", level, 3);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_rx_count", rx_count, 0);
    check("mid_rst_empty", empty, 1);
    rst = 1'b1;
    tick();
    check("mid_reaccept", ack, 1);
    check("mid_rx_count", rx_count, 1);
    exp_q.push_back(4'h3);
    send = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();

    // 256 transfers with continuous pops: counter wraps
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 256; i++) xfer(4'(i ^ (i >> 4)));
    repeat (3) tick();
    rd_en = 1'b0;
    tick();
    check("wrap_rx_count", rx_count, 0);
    check("wrap_empty", empty, 1);
    check("wrap_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_rx_fsm.md
# periph_rx_fsm

Peripheral-side receiver for the CPU send/ack handshake. It samples a data word while `send` is high, pushes the word into a small internal FIFO, and holds `ack` high until the CPU drops `send` (four-phase). A local consumer drains the FIFO through a read port. When the FIFO is full, the block withholds `ack`, which backpressures the CPU.

## Interface
- `DATA_W`, 4: data word width; matches the CPU `data` bus.
- `DEPTH`, 4: FIFO depth in words; must be a power of two and ≥ 2.
- `CNT_W`, 8: width of the received-word counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `send`  in  1  CPU request; high means `data` is valid.
- `data`  in  DATA_W  CPU data word.
- `ack`  out  1  registered acknowledge to the CPU.
- `rd_en`  in  1  consumer pop request.
- `rd_data`  out  DATA_W  registered popped word.
- `rd_valid`  out  1  one-cycle pulse, high the cycle after an accepted pop.
- `empty`  out  1  FIFO holds 0 words.
- `full`  out  1  FIFO holds DEPTH words.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `rx_count`  out  CNT_W  total accepted words; wraps modulo 2^CNT_W.

## Operation
- Reset (`rst`=0, takes effect immediately, no clock needed):
  - State is IDLE.
  - `ack`=0, `rd_data`=0, `rd_valid`=0.
  - FIFO pointers are 0, so `level`=0, `empty`=1, `full`=0.
  - `rx_count`=0.
  - FIFO contents are don't-care.
- Handshake FSM, two states:
  - **IDLE** (`ack`=0):
    - If `send`=1 and `full`=0: write `data` into the FIFO, increment `rx_count`, go to ACK.
    - If `send`=1 and `full`=1: stay in IDLE, write nothing, keep `ack` low.
    - If `send`=0: stay in IDLE.
  - **ACK** (`ack`=1):
    - Stay in ACK while `send`=1. No further write occurs, even if `data` changes.
    - When `send`=0, go to IDLE.
- `ack` is a registered output, equal to (state == ACK).
- Exactly one word is written per `send` high period.
- `full` is evaluated on the pre-pop occupancy. A pop in the same cycle does not allow a write while `full`=1.
- Read port:
  - A pop is accepted when `rd_en`=1 and `empty`=0.
  - On an accepted pop: `rd_data` takes the oldest word, the read pointer advances, and `rd_valid`=1 on the next cycle.
  - `rd_en` while empty is ignored: `rd_data` holds, `rd_valid`=0.
  - No write-to-read bypass: a word written in a cycle is poppable from the next cycle.
- Simultaneous write and pop (not empty, not full): both are performed and `level` is unchanged.
- Pointers wrap modulo DEPTH.
- `level`, `empty` and `full` are derived from pointers that carry one extra wrap bit.
- `rx_count` wraps from 2^CNT_W−1 to 0 without any flag.

## Timing
- Handshake sequence, with edge N being the first edge at which `send`=1 in IDLE with room available:
  - Edge N: the word is written and `ack` rises.
  - The CPU drops `send` after it sees `ack`.
  - The first edge at which `send`=0 in ACK drops `ack`.
  - With the CPU FSM, a full transfer takes 3 cycles (`send` up → `ack` up → `send` down → `ack` down).
- Accept latency: 1 cycle from `send` sampled high (with room) to `ack`=1.
- Release latency: 1 cycle from `send` sampled low to `ack`=0.
- Read latency: 1 cycle from the accepted `rd_en` edge to `rd_data`/`rd_valid`.
- Backpressure: while full, `ack` stays 0 indefinitely. On the edge after the first accepted pop, `full`=0 and a pending `send` is accepted on that following edge.
- Reset asserted mid-transfer: `ack` drops immediately and the FIFO empties. After release, if `send` is still 1, the word is accepted again as a new transfer.

## Test plan
- Reset, then one transfer with `data`=4'hA:
  - `ack` rises 1 cycle after `send`, falls 1 cycle after `send` drops.
  - `level`=1, `rx_count`=1.
  - Popping gives `rd_data`=4'hA with `rd_valid` pulsed once.
- `send` held high for 10 cycles with `data` toggling: exactly one word is written (the value at the accept edge) and `rx_count`=1.
- Backpressure:
  - Five back-to-back transfers of 1, 2, 3, 4, 5 with no pops: after four words, `full`=1 and the fifth `send` sees `ack`=0.
  - Pop once: `rd_data`=1, then word 5 is accepted.
  - Drain: order is 2, 3, 4, 5, then `empty`=1.
- Simultaneous write and pop at `level`=2: `level` stays 2 and the order is preserved. `rd_en` while empty leaves `rd_data` unchanged and `rd_valid`=0.
- `rst` pulsed low while in ACK with `level`=3: `ack`, `level` and `rx_count` all go to 0 asynchronously, `empty`=1. With `send` still high after release, `ack` rises on the first edge.
- 256 transfers with continuous pops: `rx_count` wraps to 0, and every word is read back in order.
